uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `txuart` transmitter between `NREQ` byte-stream requesters. It sequences `send` pulses against `txuart` `ready`, so each accepted byte produces exactly one UART frame. Optional packet locking holds the grant with one requester until that requester's `last` byte. It sits between producer blocks (LED-array status, debug dump, command echo) and the single `txuart` instance driving the board TX pin.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `LOCK_PACKETS`, default 1: when 1, the grant is held until a byte with `req_last=1`; when 0, arbitration is per byte.
- `LOCK_TIMEOUT`, default 16'd50000: idle cycles a locked owner may stall before the lock is force-released; 0 disables the timeout.

Ports (clock and reset first):
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-low.
- `req_valid`  in  NREQ  per-requester byte valid.
- `req_data`  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- `req_last`  in  NREQ  the byte ends a packet.
- `req_ready`  out  NREQ  one-hot, combinational; high in the accept cycle only.
- `tx_data`  out  8  registered byte to `txuart.data`.
- `tx_send`  out  1  registered one-cycle pulse to `txuart.send`.
- `tx_ready`  in  1  `txuart.ready`.
- `owner`  out  $clog2(NREQ)  index of the last accepted requester.
- `locked`  out  1  a packet lock is held.
- `lock_err`  out  1  one-cycle pulse on timeout release.
- `busy`  out  1  FSM not in S_IDLE.

## Operation
- FSM has three states:
  - **S_IDLE**: arbitrates only when `tx_ready=1`.
  - **S_SEND**: lasts exactly 1 cycle.
  - **S_WAIT**: waits for `tx_ready=1`, then goes to S_IDLE.
- Candidate set:
  - If `locked=1`, the candidate set is the owner only.
  - Otherwise it is all `req_valid` bits.
- Round-robin: search starts at `(owner+1) mod NREQ`. The first valid candidate wins.
- Accept in S_IDLE, in the same cycle:
  - `req_ready[w]=1`.
  - At the clock edge: `tx_data<=req_data[w]`, `owner<=w`, state goes to S_SEND.
- Lock on accept:
  - `locked<=LOCK_PACKETS & ~req_last[w]`.
  - If `req_last[w]=1`, the lock is cleared.
- `tx_send=1` exactly while in S_SEND.
- Requesters hold `valid`, `data` and `last` stable until they see `req_ready`. The block never accepts twice per frame.
- Timeout counter (16 bit):
  - Increments each S_IDLE cycle with `locked=1`, `tx_ready=1` and owner `req_valid=0`.
  - Clears on any accept and while unlocked.
  - When it equals `LOCK_TIMEOUT` (nonzero): `locked<=0`, `lock_err` pulses 1 cycle, counter clears. Arbitration opens on the next cycle.
- Simultaneous events: if the owner becomes valid in the same cycle the timeout hits, the accept wins. There is no `lock_err` and the lock follows `req_last`.
- Requesters other than the owner that are valid while locked are stalled, never dropped.

## Timing
- Reset values: state S_IDLE, `tx_send=0`, `tx_data=8'h00`, `owner=NREQ-1` (so requester 0 is first priority), `locked=0`, `lock_err=0`, `busy=0`, timeout counter 0. `req_ready=0` during reset.
- Accept cycle t → `tx_send=1` at t+1 → `txuart` `tx_ready=0` from t+2.
- `tx_ready` returns to 1 at cycle r → S_IDLE at r+1 → next accept at r+1 → next `tx_send` at r+2.
- Back-to-back bytes therefore cost 10·UART_COUNTER_MAX + 2 cycles each.
- `tx_ready=0` in S_IDLE: no accept and all `req_ready=0`.
- Reset asserted mid-frame:
  - Next cycle the FSM is in S_IDLE and the lock is cleared.
  - The pending byte is lost and is not re-accepted. The requester's handshake already completed.
  - `txuart` shares `rst`, so it idles too.

## Test plan
- Bench uses `txuart` with UART_COUNTER_MAX=4 (40-cycle frame) and NREQ=4.
- **Single byte**: req0 valid with data 8'hA5 and last=1 → `req_ready[0]` for 1 cycle, `tx_send` 1 cycle later, line shows start, 1,0,1,0,0,1,0,1, stop; `busy` falls after `tx_ready` returns.
- **Round-robin**: req0..3 all valid with last=1 continuously → grant order 0,1,2,3,0 with `tx_send` spacing of 42 cycles.
- **Packet lock**: req1 sends 3 bytes with last on the 3rd while req2 stays valid → bytes 1,1,1 are sent and then 2; `locked=1` after bytes 1 and 2 and 0 after byte 3.
- **Timeout**: LOCK_TIMEOUT=5; req3 sends a byte with last=0 then drops valid; req0 is valid → `lock_err` pulses 5 S_IDLE cycles after `tx_ready` returns, then req0 is accepted the next cycle.
- **Timeout/accept tie**: owner valid rises in the cycle the counter reaches LOCK_TIMEOUT → owner is accepted, `lock_err` stays 0.
- **Mid-frame reset**: `rst=0` for 1 cycle during data bit 3 → next cycle `busy=0`, `locked=0`, `tx_send=0`, line high; the next valid request is accepted normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// ----------------------------------------------------------------------------
// Shares a single txuart transmitter between NREQ byte-stream requesters.
// One byte is accepted per UART frame: the accept loads tx_data, a one-cycle
// tx_send pulse follows, and the block then waits for txuart ready to return
// before it arbitrates again. Arbitration is round-robin, starting one past
// the last accepted requester. With LOCK_PACKETS=1 the grant stays with one
// requester until it delivers a byte flagged req_last. A lock whose owner
// stalls for LOCK_TIMEOUT idle cycles is force-released with a lock_err pulse.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous, active-low reset
//   req_valid  in   [NREQ-1:0]   per-requester byte valid
//   req_data   in   [8*NREQ-1:0] byte of requester i in bits [8i+7:8i]
//   req_last   in   [NREQ-1:0]   byte ends a packet
//   req_ready  out  [NREQ-1:0]   one-hot accept strobe (combinational)
//   tx_data    out  [7:0]        byte to txuart.data (registered)
//   tx_send    out               one-cycle send pulse to txuart (registered)
//   tx_ready   in                txuart.ready
//   owner      out  [$clog2(NREQ)-1:0] last accepted requester
//   locked     out               a packet lock is held
//   lock_err   out               one-cycle pulse on timeout release
//   busy       out               FSM is not idle
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          LOCK_PACKETS = 1,
  parameter logic [15:0] LOCK_TIMEOUT = 16'd50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [8*NREQ-1:0]         req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_send,
  input  logic                      tx_ready,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      locked,
  output logic                      lock_err,
  output logic                      busy
);

  localparam int OW = $clog2(NREQ);
  localparam int IW = OW + 1;
  localparam logic [IW-1:0] NREQ_W = IW'(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  // Round-robin pick: returns {found, index}. The scan runs from the farthest
  // position back to owner+1 so the closest valid candidate is written last.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] cand,
                                            input logic [OW-1:0]   last_idx);
    logic [IW-1:0] res;
    logic [IW-1:0] idx;
    res = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = {1'b0, last_idx} + IW'(i);
      if (idx >= NREQ_W) begin
        idx = idx - NREQ_W;
      end else begin
        idx = idx;
      end
      if (cand[idx[OW-1:0]]) begin
        res = {1'b1, idx[OW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_send_q, tx_send_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            locked_q, locked_d;
  logic            busy_q, busy_d;
  logic [15:0]     cnt_q, cnt_d;

  logic [NREQ-1:0] owner_mask_s;
  logic [NREQ-1:0] cand_s;
  logic [IW-1:0]   pick_s;
  logic [OW-1:0]   win_s;
  logic            accept_s;
  logic            stall_s;
  logic            hit_s;
  logic [NREQ-1:0] req_ready_s;
  logic            lock_err_s;

  // Candidate set and round-robin winner.
  always_comb begin
    owner_mask_s = NREQ'(1) << owner_q;
    if (locked_q) begin
      cand_s = req_valid & owner_mask_s;
    end else begin
      cand_s = req_valid;
    end
    pick_s   = rr_pick(cand_s, owner_q);
    win_s    = pick_s[OW-1:0];
    accept_s = (state_q == S_IDLE) && tx_ready && pick_s[OW];
    // A locked owner with nothing to send while the UART is free is stalling.
    stall_s  = locked_q && tx_ready && !req_valid[owner_q];
    hit_s    = (LOCK_TIMEOUT != 16'd0) && locked_q && (cnt_q == LOCK_TIMEOUT);
  end

  // Next-state logic for the FSM, lock and timeout counter.
  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    owner_d     = owner_q;
    locked_d    = locked_q;
    cnt_d       = cnt_q;
    req_ready_s = '0;
    lock_err_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // An accept takes priority over a timeout landing in the same cycle.
        if (accept_s) begin
          req_ready_s = NREQ'(1) << win_s;
          tx_data_d   = req_data[{win_s, 3'b000} +: 8];
          owner_d     = win_s;
          locked_d    = (LOCK_PACKETS != 0) && !req_last[win_s];
          cnt_d       = 16'd0;
          state_d     = S_SEND;
        end else if (hit_s) begin
          locked_d   = 1'b0;
          cnt_d      = 16'd0;
          lock_err_s = 1'b1;
        end else if (stall_s) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_SEND: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!locked_q) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_d;
    end

    tx_send_d = (state_d == S_SEND);
    busy_d    = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tx_data_q <= 8'h00;
      tx_send_q <= 1'b0;
      owner_q   <= OW'(NREQ - 1);
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  // The accept strobe and the timeout pulse are forced low while in reset.
  assign req_ready = rst ? req_ready_s : '0;
  assign lock_err  = rst & lock_err_s;
  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign owner     = owner_q;
  assign locked    = locked_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with a small behavioural txuart
// (UART_COUNTER_MAX=4, 40-cycle frame), NREQ=4 and LOCK_TIMEOUT=5.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_ready;
  logic [1:0]  owner;
  logic        locked;
  logic        lock_err;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_send = 0;

  uart_tx_arbiter #(
    .NREQ(4),
    .LOCK_PACKETS(1),
    .LOCK_TIMEOUT(16'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_ready(tx_ready),
    .owner(owner),
    .locked(locked),
    .lock_err(lock_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural txuart: 10 bits x 4 cycles; ready reasserts in the last
  // cycle of the stop bit.
  logic       u_active;
  logic [5:0] u_cnt;
  logic [7:0] u_sh;
  logic [9:0] u_frame;
  logic       line;

  always @(posedge clk) begin
    if (!rst) begin
      u_active <= 1'b0;
      u_cnt    <= 6'd0;
      u_sh     <= 8'h00;
    end else if (tx_send && tx_ready) begin
      u_active <= 1'b1;
      u_cnt    <= 6'd0;
      u_sh     <= tx_data;
    end else if (u_active) begin
      if (u_cnt == 6'd39) u_active <= 1'b0;
      u_cnt <= u_cnt + 6'd1;
    end
  end

  assign tx_ready = !u_active || (u_cnt == 6'd39);
  assign u_frame  = {1'b1, u_sh, 1'b0};
  assign line     = u_active ? u_frame[u_cnt[5:2]] : 1'b1;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_owner;
    logic        exp_locked;
    logic [7:0]  exp_data;
    logic        gap;
  } vec_t;

  vec_t vecs [9];
  vec_t tv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Present one request pattern, wait for its accept, then check the send cycle.
  task automatic run_vec(input vec_t v, input string nm);
    int c;
    req_valid = v.valid;
    req_data  = v.data;
    req_last  = v.last;
    c = 0;
    #1;
    while (req_ready == 4'b0000 && c < 200) begin
      tick();
      #1;
      c++;
    end
    chk({nm, ".grant"}, req_ready, v.exp_ready);
    tick();
    chk({nm, ".send"},   tx_send, 1'b1);
    chk({nm, ".noreacc"}, req_ready, 4'b0000);
    chk({nm, ".data"},   tx_data, v.exp_data);
    chk({nm, ".owner"},  owner, v.exp_owner);
    chk({nm, ".locked"}, locked, v.exp_locked);
    chk({nm, ".busy"},   busy, 1'b1);
    if (v.gap) chk({nm, ".gap"}, cyc - last_send, 42);
    last_send = cyc;
  endtask

  // From the send cycle, advance to the first cycle where txuart is ready again.
  task automatic wait_return();
    int c;
    c = 0;
    tick();
    while (!tx_ready && c < 100) begin
      tick();
      c++;
    end
    chk("wait_return", tx_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    // round robin: req i carries byte {i+10,i} hex
    vecs[0] = '{4'hF, 32'hD3C2B1A0, 4'hF, 4'b0001, 2'd0, 1'b0, 8'hA0, 1'b0};
    vecs[1] = '{4'hF, 32'hD3C2B1A0, 4'hF, 4'b0010, 2'd1, 1'b0, 8'hB1, 1'b1};
    vecs[2] = '{4'hF, 32'hD3C2B1A0, 4'hF, 4'b0100, 2'd2, 1'b0, 8'hC2, 1'b1};
    vecs[3] = '{4'hF, 32'hD3C2B1A0, 4'hF, 4'b1000, 2'd3, 1'b0, 8'hD3, 1'b1};
    vecs[4] = '{4'hF, 32'hD3C2B1A0, 4'hF, 4'b0001, 2'd0, 1'b0, 8'hA0, 1'b1};
    // packet lock: req1 sends 11,12,13 (last on 13) while req2 waits
    vecs[5] = '{4'b0110, 32'h00221100, 4'b0100, 4'b0010, 2'd1, 1'b1, 8'h11, 1'b1};
    vecs[6] = '{4'b0110, 32'h00221200, 4'b0100, 4'b0010, 2'd1, 1'b1, 8'h12, 1'b1};
    vecs[7] = '{4'b0110, 32'h00221300, 4'b0110, 4'b0010, 2'd1, 1'b0, 8'h13, 1'b1};
    vecs[8] = '{4'b0100, 32'h00220000, 4'b0100, 4'b0100, 2'd2, 1'b0, 8'h22, 1'b1};

    // reset with all requesters valid: nothing may be accepted
    rst = 1'b0;
    req_valid = 4'hF;
    req_data  = 32'hD3C2B1A0;
    req_last  = 4'hF;
    repeat (2) tick();
    chk("rst.ready",    req_ready, 4'b0000);
    chk("rst.busy",     busy, 1'b0);
    chk("rst.send",     tx_send, 1'b0);
    chk("rst.data",     tx_data, 8'h00);
    chk("rst.owner",    owner, 2'd3);
    chk("rst.locked",   locked, 1'b0);
    chk("rst.lock_err", lock_err, 1'b0);
    rst = 1'b1;
    req_valid = 4'h0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("v%0d", i));
    req_valid = 4'h0;

    // single byte A5 from req0 and its line waveform
    tv = '{4'b0001, 32'h000000A5, 4'b0001, 4'b0001, 2'd0, 1'b0, 8'hA5, 1'b1};
    run_vec(tv, "single");
    req_valid = 4'h0;
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 3 : 4) tick();
      chk($sformatf("single.line%0d", k), line, ((k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tv.exp_data[k-1]));
    end
    begin
      int c;
      c = 0;
      while (!tx_ready && c < 20) begin
        tick();
        c++;
      end
    end
    chk("single.busy_at_ready", busy, 1'b1);
    tick();
    chk("single.busy_fall", busy, 1'b0);

    // timeout: req3 opens a packet and goes quiet, req0 waits
    tv = '{4'b1001, 32'h33000044, 4'b0001, 4'b1000, 2'd3, 1'b1, 8'h33, 1'b1};
    run_vec(tv, "to.open");
    req_valid = 4'b0001;
    wait_return();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("to.stall%0d.err", k), lock_err, 1'b0);
      chk($sformatf("to.stall%0d.ready", k), req_ready, 4'b0000);
    end
    tick();
    chk("to.err_pulse", lock_err, 1'b1);
    chk("to.err_ready", req_ready, 4'b0000);
    tick();
    chk("to.accept_cycle", req_ready, 4'b0001);
    chk("to.err_one_cycle", lock_err, 1'b0);
    tv = '{4'b0001, 32'h33000044, 4'b0001, 4'b0001, 2'd0, 1'b0, 8'h44, 1'b0};
    run_vec(tv, "to.req0");
    last_send = cyc;

    // timeout/accept tie: owner returns exactly when the counter hits 5
    tv = '{4'b0001, 32'h00000055, 4'b0000, 4'b0001, 2'd0, 1'b1, 8'h55, 1'b1};
    run_vec(tv, "tie.open");
    req_valid = 4'b0010;
    req_data  = 32'h00006600;
    req_last  = 4'b0010;
    wait_return();
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("tie.stall%0d.ready", k), req_ready, 4'b0000);
    end
    tick();
    req_valid = 4'b0011;
    req_data  = 32'h00006656;
    req_last  = 4'b0011;
    #1;
    chk("tie.grant", req_ready, 4'b0001);
    chk("tie.no_err", lock_err, 1'b0);
    tv = '{4'b0011, 32'h00006656, 4'b0011, 4'b0001, 2'd0, 1'b0, 8'h56, 1'b0};
    run_vec(tv, "tie.acc");
    tv = '{4'b0010, 32'h00006600, 4'b0010, 4'b0010, 2'd1, 1'b0, 8'h66, 1'b1};
    run_vec(tv, "tie.next");

    // mid-frame reset during data bit 3 of 8'h3C
    tv = '{4'b0100, 32'h003C0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 8'h3C, 1'b1};
    run_vec(tv, "mr.open");
    req_valid = 4'h0;
    repeat (18) tick();
    chk("mr.bit3", line, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mr.busy",   busy, 1'b0);
    chk("mr.locked", locked, 1'b0);
    chk("mr.send",   tx_send, 1'b0);
    chk("mr.line",   line, 1'b1);
    chk("mr.owner",  owner, 2'd3);
    tv = '{4'b1000, 32'h77000000, 4'b1000, 4'b1000, 2'd3, 1'b0, 8'h77, 1'b0};
    run_vec(tv, "mr.after");
    req_valid = 4'h0;
    wait_return();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
